// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection path: scheduler state encoding,
// flit width helper and the destination field offsets inside a flit.
// Flit layout (MSB..LSB): {dest_x, dest_y, payload}.
package noc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  // Total flit width for a given destination/payload geometry.
  function automatic int tw(input int x_size, input int y_size, input int data_width);
    return x_size + y_size + data_width;
  endfunction

  // LSB position of the destination Y field.
  function automatic int y_offset(input int data_width);
    return data_width;
  endfunction

  // LSB position of the destination X field.
  function automatic int x_offset(input int y_size, input int data_width);
    return data_width + y_size;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping. The caller owns and advances the pointer register.
module noc_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  // Scan from the pointer position; the first hit wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Per-node injection scheduler: round-robin shares one NoC PE injection port
// among NUM_REQ local sources, spaces grants at least RATE cycles apart and
// counts accepted flits against a packet budget, raising done when finished.
// Optional macro INJECT_STATS_EN adds stall_cycles / run_cycles counters.
module noc_inject_scheduler
  import noc_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int x_size     = 2,
  parameter  int y_size     = 2,
  parameter  int data_width = 256,
  parameter  int RATE       = 1,
  parameter  int CNT_W      = 16,
  localparam int TW         = tw(x_size, y_size, data_width)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_REQ-1:0]    enable,
  input  logic [CNT_W-1:0]      pkt_budget,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*TW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  o_valid,
  output logic [TW-1:0]         o_data,
  input  logic                  i_ready,
  output logic [CNT_W-1:0]      sent_count,
  output logic                  busy,
`ifdef INJECT_STATS_EN
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      run_cycles,
`endif
  output logic                  done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RATE - 1);

  state_e               state_q, state_d;
  logic                 o_valid_q, o_valid_d;
  logic [TW-1:0]        o_data_q, o_data_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [CNT_W-1:0]     sent_q, sent_d;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]     arb_idx;
  logic                 accept;
  logic                 grant_en;

  noc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Grant qualification, datapath updates and next-state selection.
  always_comb begin
    eligible    = req_valid & enable;
    accept      = o_valid_q & i_ready;
    grant_en    = (state_q == RUN) && start && (gap_q == '0) &&
                  (remaining_q != '0) && (!o_valid_q || i_ready) && (|eligible);
    state_d     = state_q;
    o_valid_d   = o_valid_q;
    o_data_d    = o_data_q;
    ptr_d       = ptr_q;
    gap_d       = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    req_ready   = grant_en ? arb_grant : '0;

    if (accept) begin
      o_valid_d = 1'b0;
      if (sent_q != '1) sent_d = sent_q + 1'b1;
    end

    if (grant_en) begin
      o_valid_d   = 1'b1;
      o_data_d    = req_data[arb_idx*TW +: TW];
      ptr_d       = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
      remaining_d = remaining_q - 1'b1;
      gap_d       = GAP_LOAD;
    end

    case (state_q)
      IDLE: if (start) begin
        remaining_d = pkt_budget;
        sent_d      = '0;
        state_d     = (pkt_budget == '0) ? DONE : RUN;
      end
      // An abort still lets a flit granted this cycle go out through DRAIN.
      RUN: begin
        if (!start)                              state_d = DRAIN;
        else if (remaining_d == '0 && !o_valid_d) state_d = DONE;
      end
      DRAIN: if (!o_valid_d) state_d = IDLE;
      DONE:  if (!start)     state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      ptr_q       <= '0;
      gap_q       <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q     <= state_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign sent_count = sent_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

`ifdef INJECT_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] run_q, run_d;

  // Saturating activity counters; cleared on IDLE->RUN, frozen outside RUN/DRAIN.
  always_comb begin
    stall_d = stall_q;
    run_d   = run_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
      run_d   = '0;
    end else if (state_q == RUN || state_q == DRAIN) begin
      if (run_q != '1) run_d = run_q + 1'b1;
      if (o_valid_q && !i_ready && stall_q != '1) stall_d = stall_q + 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      run_q   <= '0;
    end else begin
      stall_q <= stall_d;
      run_q   <= run_d;
    end
  end

  assign stall_cycles = stall_q;
  assign run_cycles   = run_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Self-checking bench for noc_inject_scheduler: a table of per-cycle vectors
// for the round-robin and masked-enable runs, plus hand-written sequences for
// rate spacing, backpressure, abort/drain, zero budget and mid-run reset.
module tb_noc_inject_scheduler;

  localparam int NR    = 4;
  localparam int TW    = 260;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start;
  logic [NR-1:0]     enable;
  logic [CNT_W-1:0]  pkt_budget;
  logic [NR-1:0]     req_valid;
  logic [NR*TW-1:0]  req_data;
  logic              i_ready;

  logic [NR-1:0]     req_ready, r4_req_ready;
  logic              o_valid, r4_o_valid;
  logic [TW-1:0]     o_data, r4_o_data;
  logic [CNT_W-1:0]  sent_count, r4_sent_count;
  logic              busy, r4_busy, done, r4_done;
`ifdef INJECT_STATS_EN
  logic [CNT_W-1:0]  stall_cycles, run_cycles, r4_stall_cycles, r4_run_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_inject_scheduler #(.NUM_REQ(NR), .RATE(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .pkt_budget(pkt_budget),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .sent_count(sent_count), .busy(busy),
`ifdef INJECT_STATS_EN
    .stall_cycles(stall_cycles), .run_cycles(run_cycles),
`endif
    .done(done)
  );

  noc_inject_scheduler #(.NUM_REQ(NR), .RATE(4), .CNT_W(CNT_W)) dut_r4 (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .pkt_budget(pkt_budget),
    .req_valid(req_valid), .req_data(req_data), .req_ready(r4_req_ready),
    .o_valid(r4_o_valid), .o_data(r4_o_data), .i_ready(i_ready),
    .sent_count(r4_sent_count), .busy(r4_busy),
`ifdef INJECT_STATS_EN
    .stall_cycles(r4_stall_cycles), .run_cycles(r4_run_cycles),
`endif
    .done(r4_done)
  );

  typedef struct {
    logic             start;
    logic [CNT_W-1:0] budget;
    logic [NR-1:0]    en;
    logic [NR-1:0]    rv;
    logic             ir;
    logic [NR-1:0]    exp_rr;
    logic             exp_ov;
    int               exp_src;   // -1: o_data not checked
    logic [CNT_W-1:0] exp_sent;
    logic             exp_done;
    logic             exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic st, int bud, logic [3:0] en, logic [3:0] rv, logic ir,
                               logic [3:0] rr, logic ov, int src, int sent, logic dn, logic bz);
    vec_t v;
    v.start = st; v.budget = CNT_W'(bud); v.en = en; v.rv = rv; v.ir = ir;
    v.exp_rr = rr; v.exp_ov = ov; v.exp_src = src; v.exp_sent = CNT_W'(sent);
    v.exp_done = dn; v.exp_busy = bz;
    return v;
  endfunction

  // Distinct flit per requester: {x, y, payload}.
  function automatic logic [TW-1:0] flit(int i);
    logic [255:0] d;
    d = 256'(64'hC0DE_0000_0000_0000) + 256'(i * 32'h0111);
    return {2'(i), 2'(3 - i), d};
  endfunction

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic st, input int bud, input logic [3:0] en,
                       input logic [3:0] rv, input logic ir);
    start = st; pkt_budget = CNT_W'(bud); enable = en; req_valid = rv; i_ready = ir;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < NR; i++) req_data[i*TW +: TW] = flit(i);

    // Budget 8, all requesters, RATE=1: strict 0,1,2,3 rotation every cycle.
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0000, 0, -1, 0, 0, 0));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0001, 0, -1, 0, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0010, 1,  0, 0, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0100, 1,  1, 1, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b1000, 1,  2, 2, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0001, 1,  3, 3, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0010, 1,  0, 4, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0100, 1,  1, 5, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b1000, 1,  2, 6, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0000, 1,  3, 7, 0, 1));
    vecs.push_back(mkv(1, 8, 4'hF, 4'hF, 1, 4'b0000, 0, -1, 8, 1, 0));
    vecs.push_back(mkv(0, 8, 4'hF, 4'hF, 1, 4'b0000, 0, -1, 8, 1, 0));
    vecs.push_back(mkv(0, 8, 4'hF, 4'hF, 1, 4'b0000, 0, -1, 8, 0, 0));
    // Budget 6, enable=0101: only requesters 0 and 2 ever granted.
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0000, 0, -1, 8, 0, 0));
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0001, 0, -1, 0, 0, 1));
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0100, 1,  0, 0, 0, 1));
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0001, 1,  2, 1, 0, 1));
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0100, 1,  0, 2, 0, 1));
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0001, 1,  2, 3, 0, 1));
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0100, 1,  0, 4, 0, 1));
    vecs.push_back(mkv(1, 6, 4'h5, 4'hF, 1, 4'b0000, 1,  2, 5, 0, 1));
    vecs.push_back(mkv(0, 6, 4'h5, 4'hF, 1, 4'b0000, 0, -1, 6, 1, 0));
    vecs.push_back(mkv(0, 6, 4'h5, 4'hF, 1, 4'b0000, 0, -1, 6, 0, 0));

    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst o_valid", TW'(o_valid), TW'(0));
    check("rst o_data", o_data, TW'(0));
    check("rst req_ready", TW'(req_ready), TW'(0));
    check("rst sent", TW'(sent_count), TW'(0));
    check("rst busy_done", TW'({busy, done}), TW'(0));
    @(negedge clk);
    rst = 1'b0;

    // Table-driven runs.
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].start, int'(vecs[k].budget), vecs[k].en, vecs[k].rv, vecs[k].ir);
      #1;
      check($sformatf("vec%0d req_ready", k), TW'(req_ready), TW'(vecs[k].exp_rr));
      check($sformatf("vec%0d o_valid", k), TW'(o_valid), TW'(vecs[k].exp_ov));
      check($sformatf("vec%0d sent", k), TW'(sent_count), TW'(vecs[k].exp_sent));
      check($sformatf("vec%0d done", k), TW'(done), TW'(vecs[k].exp_done));
      check($sformatf("vec%0d busy", k), TW'(busy), TW'(vecs[k].exp_busy));
      if (vecs[k].exp_src >= 0)
        check($sformatf("vec%0d o_data", k), o_data, flit(vecs[k].exp_src));
      @(negedge clk);
    end

    // RATE=4, budget 3, single requester: o_valid at t, t+4, t+8.
    do_reset();
    drive(1, 3, 4'hF, 4'b0001, 1);
    for (int t = 0; t < 12; t++) begin
      #1;
      check($sformatf("rate t%0d req_ready", t), TW'(r4_req_ready),
            TW'((t == 1 || t == 5 || t == 9) ? 4'b0001 : 4'b0000));
      check($sformatf("rate t%0d o_valid", t), TW'(r4_o_valid),
            TW'((t == 2 || t == 6 || t == 10) ? 1'b1 : 1'b0));
      if (t == 11) begin
        check("rate done", TW'(r4_done), TW'(1));
        check("rate sent", TW'(r4_sent_count), TW'(3));
      end
      @(negedge clk);
    end

    // Budget 4, backpressure for 5 cycles after the first flit.
    do_reset();
    drive(1, 4, 4'hF, 4'hF, 1);
    for (int t = 0; t < 8; t++) begin
      i_ready = (t >= 2 && t <= 6) ? 1'b0 : 1'b1;
      #1;
      if (t == 1) check("bp first grant", TW'(req_ready), TW'(4'b0001));
      if (t >= 2 && t <= 6) begin
        check($sformatf("bp t%0d no grant", t), TW'(req_ready), TW'(0));
        check($sformatf("bp t%0d o_valid", t), TW'(o_valid), TW'(1));
        check($sformatf("bp t%0d o_data held", t), o_data, flit(0));
      end
      if (t == 7) begin
        check("bp resume grant", TW'(req_ready), TW'(4'b0010));
`ifdef INJECT_STATS_EN
        check("bp stall_cycles", TW'(stall_cycles), TW'(5));
`endif
      end
      @(negedge clk);
    end
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    #1;
    check("bp done", TW'(done), TW'(1));
    check("bp sent", TW'(sent_count), TW'(4));
    @(negedge clk);

    // Abort with a pending, stalled flit: drain, then IDLE with done=0.
    do_reset();
    drive(1, 10, 4'hF, 4'hF, 1);
    for (int t = 0; t < 8; t++) begin
      if (t == 4) begin start = 1'b0; i_ready = 1'b0; end
      if (t == 6) i_ready = 1'b1;
      #1;
      if (t == 3) check("abort third grant", TW'(req_ready), TW'(4'b0100));
      if (t >= 4 && t <= 6) begin
        check($sformatf("abort t%0d no grant", t), TW'(req_ready), TW'(0));
        check($sformatf("abort t%0d busy", t), TW'(busy), TW'(1));
        check($sformatf("abort t%0d o_data", t), o_data, flit(2));
      end
      if (t == 7) begin
        check("abort idle busy", TW'(busy), TW'(0));
        check("abort done", TW'(done), TW'(0));
        check("abort sent", TW'(sent_count), TW'(3));
        check("abort o_valid", TW'(o_valid), TW'(0));
      end
      @(negedge clk);
    end

    // Zero budget: straight to DONE, never a grant.
    drive(1, 0, 4'hF, 4'hF, 1);
    #1 check("zb idle req_ready", TW'(req_ready), TW'(0));
    @(negedge clk);
    #1;
    check("zb done", TW'(done), TW'(1));
    check("zb req_ready", TW'(req_ready), TW'(0));
    check("zb sent", TW'(sent_count), TW'(0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 check("zb cleared", TW'(done), TW'(0));
    @(negedge clk);

    // Reset mid-RUN with a flit in flight.
    drive(1, 10, 4'hF, 4'hF, 1);
    for (int t = 0; t < 3; t++) @(negedge clk);
    #1;
    check("mid pre sent", TW'(sent_count), TW'(1));
    check("mid pre o_valid", TW'(o_valid), TW'(1));
    rst = 1'b1;
    #1;
    check("mid rst o_valid", TW'(o_valid), TW'(0));
    check("mid rst o_data", o_data, TW'(0));
    check("mid rst req_ready", TW'(req_ready), TW'(0));
    check("mid rst sent", TW'(sent_count), TW'(0));
    check("mid rst busy_done", TW'({busy, done}), TW'(0));
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_inject_scheduler.md
Name: noc_inject_scheduler

Overview:
Per-node injection controller placed between up to NUM_REQ local traffic sources and one PE injection port of the NoC top.
- Shares the port between sources with round-robin arbitration.
- Enforces a minimum injection interval of RATE cycles.
- Counts packets against a programmable budget and raises done when the budget is fully accepted by the NoC.
- Replaces ad-hoc rate/done logic in traffic-generator PEs.

Parameters:
- NUM_REQ, 4, number of local requesters (2..8)
- x_size, 2, destination X field width
- y_size, 2, destination Y field width
- data_width, 256, payload width
- RATE, 1, minimum cycles between two injection grants (1 = back-to-back)
- CNT_W, 16, width of the budget and sent counters
- TW (localparam), x_size+y_size+data_width, flit width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  level; 1 = run, 0 = abort/return to idle
- enable  in  NUM_REQ  per-requester mask; masked requesters are never granted
- pkt_budget  in  CNT_W  packets to inject; sampled on IDLE->RUN
- req_valid  in  NUM_REQ  requester i has a flit
- req_data  in  NUM_REQ*TW  flit of requester i at bits [i*TW +: TW]
- req_ready  out  NUM_REQ  one-hot; flit of requester i is consumed this cycle
- o_valid  out  1  flit toward NoC (r_valid_pe side)
- o_data  out  TW  flit toward NoC
- i_ready  in  1  NoC accepts flit
- sent_count  out  CNT_W  flits accepted by NoC since last IDLE->RUN
- busy  out  1  state is RUN or DRAIN
- done  out  1  budget completed

Behaviour:
- Reset: state=IDLE; o_valid=0; o_data=0; req_ready=0; sent_count=0; done=0; busy=0; rr pointer=0; gap counter=0; remaining=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start=1, load remaining=pkt_budget and clear sent_count. If pkt_budget=0, go to DONE; otherwise go to RUN.
- RUN, grant condition: gap=0, remaining>0, (o_valid=0 or i_ready=1), and some (req_valid & enable) bit set.
- Grant effects, same cycle:
  - req_ready[g]=1 combinationally, where g is the first eligible index at or after the rr pointer, wrapping.
  - Next cycle: o_data=req_data[g], o_valid=1, rr pointer=(g+1) mod NUM_REQ, remaining-1, gap=RATE-1.
- gap decrements each cycle while non-zero.
- o_valid/o_data are held stable until i_ready=1. Each o_valid&i_ready increments sent_count, saturating at all-ones.
- Throughput: with RATE=1 and i_ready held at 1, sustains one flit per cycle. Grant-to-o_valid latency is 1 cycle.
- Completion: remaining=0 and output accepted (o_valid=0 next cycle) -> DONE.
- Abort: start=0 in RUN -> no new grants; go to DRAIN. The pending flit waits for i_ready, then -> IDLE. done stays 0.
- Simultaneous events: if start falls in the same cycle as a grant, the grant completes and the flit drains.
- DONE: done=1 held. start=0 -> IDLE with done cleared. No grants in DONE.
- req_ready is never asserted outside RUN and never for a requester with enable=0.
- enable changing mid-run takes effect on the next arbitration.
- Asynchronous reset at any point returns everything to reset values; an in-flight flit is dropped.

Optional Feature:
Macro INJECT_STATS_EN.
- With it: extra outputs stall_cycles (CNT_W) and run_cycles (CNT_W), both cleared on IDLE->RUN.
  - stall_cycles counts cycles with o_valid=1 & i_ready=0.
  - run_cycles counts cycles in RUN or DRAIN.
  - Both saturate and freeze in DONE so the bench can compute throughput = sent_count/run_cycles.
- Without it: the ports and counters are absent.

Decomposition:
- Shared package noc_pkg holds:
  - state encoding localparams: IDLE=0, RUN=1, DRAIN=2, DONE=3
  - flit width function tw(x_size, y_size, data_width)
  - field offsets for the destination X/Y fields within a flit
- One sub-module: noc_rr_arbiter.
  - Parameter NUM_REQ; inputs req, ptr; outputs one-hot grant and grant index; purely combinational.
  - The scheduler owns the pointer register.

Test Plan:
- Budget=8, RATE=1, all four requesters valid, i_ready=1 -> grants in order 0,1,2,3,0,1,2,3 on consecutive cycles; sent_count=8; done asserted 1 cycle after the last accept.
- RATE=4, budget=3, single requester -> o_valid rises at cycles t, t+4, t+8; no req_ready pulse between them.
- Budget=4, i_ready=0 for 5 cycles after the first flit -> o_data held stable; no further grants; stall_cycles=5 with INJECT_STATS_EN.
- enable=4'b0101, all req_valid=1, budget=6 -> grants only 0,2,0,2,0,2.
- start dropped after 2 of 10 flits while o_valid=1 and i_ready=0 -> DRAIN until i_ready; sent_count=3; IDLE; done=0.
- pkt_budget=0 with start=1 -> DONE next cycle, no req_ready; rst asserted mid-RUN -> all outputs 0 immediately.
